// File: rtl/mp3player_soc_pkg.sv
// mp3player_soc_pkg: shared constants for the MP3 player SoC peripherals
//   ADDR_*                  Avalon word addresses of the switch controller registers
//   CLK_FREQ_HZ             system clock frequency
//   DEBOUNCE_CYCLES_DEFAULT debounce hold time in clk cycles (10 ms)
package mp3player_soc_pkg;
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_MASK     = 2'd1;
    localparam logic [1:0] ADDR_CAPTURE  = 2'd2;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;
    localparam int CLK_FREQ_HZ             = 50_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_FREQ_HZ / 100;
endpackage

// File: rtl/mp3player_soc_debounce_bit.sv
// mp3player_soc_debounce_bit: synchronise, debounce and edge-detect one switch input
//   clk, reset_n  clock, asynchronous active-low reset
//   primed        0 while stable just tracks the synchroniser after reset
//   raw           asynchronous switch level
//   stable        debounced level
//   rise_pulse    one-cycle pulse on the edge where stable goes 0->1
//   fall_pulse    one-cycle pulse on the edge where stable goes 1->0
module mp3player_soc_debounce_bit
    import mp3player_soc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset_n,
    input  logic primed,
    input  logic raw,
    output logic stable,
    output logic rise_pulse,
    output logic fall_pulse
);
    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             done;

    assign done       = primed && (sync != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise_pulse = done & ~stable;
    assign fall_pulse = done & stable;

    // Before priming, stable follows sync without pulses so power-up levels never look like edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (!primed) begin
                stable <= sync;
                cnt    <= '0;
            end else if (done) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= (sync == stable) ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mp3player_soc_switch_ctrl.sv
// mp3player_soc_switch_ctrl: Avalon-MM switch/button controller with debounce, edge capture and irq
//   clk, reset_n                          clock, asynchronous active-low reset
//   address, chipselect, write_n, writedata  Avalon slave write side
//   readdata                              registered read data, 1-cycle latency
//   in_port                               raw switch/button levels
//   irq                                   registered |(capture & mask)
module mp3player_soc_switch_ctrl
    import mp3player_soc_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [1:0]       prime_cnt;
    logic             primed;
    logic [WIDTH-1:0] stable, rise, fall, event_v, clr;
    logic [WIDTH-1:0] mask, capture, edge_sel, wdata;
    logic [31:0]      rd_sel;
    logic             wr;
    logic             unused_ok;

    assign unused_ok = ^writedata;
    assign wr        = chipselect & ~write_n;
    assign wdata     = writedata[WIDTH-1:0];
    assign event_v   = (rise & ~edge_sel) | (fall & edge_sel);
    assign clr       = (wr && address == ADDR_CAPTURE) ? wdata : '0;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            mp3player_soc_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_bit (
                .clk       (clk),
                .reset_n   (reset_n),
                .primed    (primed),
                .raw       (in_port[i]),
                .stable    (stable[i]),
                .rise_pulse(rise[i]),
                .fall_pulse(fall[i])
            );
        end
    endgenerate

    always_comb begin
        rd_sel            = '0;
        rd_sel[WIDTH-1:0] = (address == ADDR_DATA)    ? stable  :
                            (address == ADDR_MASK)    ? mask    :
                            (address == ADDR_CAPTURE) ? capture : edge_sel;
    end

    // primed rises on the 3rd edge after reset, once the synchronisers hold real input levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
            primed    <= 1'b0;
            mask      <= '0;
            capture   <= '0;
            edge_sel  <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            if (!primed) begin
                prime_cnt <= prime_cnt + 1'b1;
                primed    <= (prime_cnt == 2'd2);
            end
            if (wr && address == ADDR_MASK)
                mask <= wdata;
            if (wr && address == ADDR_EDGE_SEL)
                edge_sel <= wdata;
            capture  <= (capture & ~clr) | event_v;
            readdata <= rd_sel;
            irq      <= |(capture & mask);
        end
    end
endmodule

// File: tb/tb_mp3player_soc_switch_ctrl.sv
// tb_mp3player_soc_switch_ctrl: directed self-checking bench for the switch controller
module tb_mp3player_soc_switch_ctrl;
    import mp3player_soc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  in_port;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mp3player_soc_switch_ctrl #(
        .WIDTH          (10),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // All driving and sampling happens 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic av_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        tick(1);
        check(tag, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 10'h005;
        tick(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(4);
        check("prime_data", readdata, 32'h005);
        check("prime_irq", {31'b0, irq}, 32'h0);
        av_read("prime_capture", ADDR_CAPTURE, 32'h0);

        // Bit0 low first (falling edge is not an event with edge_sel=0).
        in_port = 10'h004;
        tick(8);
        av_read("fall0_data", ADDR_DATA, 32'h004);
        av_read("fall0_capture", ADDR_CAPTURE, 32'h0);

        // Bit0 rises: stable changes on the 6th edge, readdata one edge later.
        av_write(ADDR_MASK, 32'h001);
        address = ADDR_DATA;
        in_port = 10'h005;
        tick(6);
        check("rise0_data_pre", readdata, 32'h004);
        check("rise0_irq_pre", {31'b0, irq}, 32'h0);
        tick(1);
        check("rise0_data_post", readdata, 32'h005);
        check("rise0_irq_post", {31'b0, irq}, 32'h1);
        av_read("rise0_capture", ADDR_CAPTURE, 32'h001);
        av_write(ADDR_CAPTURE, 32'h001);
        tick(1);
        check("w1c_irq", {31'b0, irq}, 32'h0);
        check("w1c_capture", readdata, 32'h0);

        // Bit3 glitch of 3 cycles is rejected.
        address = ADDR_DATA;
        in_port = 10'h00D;
        tick(3);
        in_port = 10'h005;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("glitch_data", readdata, 32'h005);
            check("glitch_irq", {31'b0, irq}, 32'h0);
        end
        av_read("glitch_capture", ADDR_CAPTURE, 32'h0);

        // Bit1 with falling-edge select.
        av_write(ADDR_MASK, 32'h003);
        av_write(ADDR_EDGE_SEL, 32'h002);
        av_read("edgesel_rd", ADDR_EDGE_SEL, 32'h002);
        in_port = 10'h007;
        tick(8);
        av_read("b1_rise_data", ADDR_DATA, 32'h007);
        av_read("b1_rise_capture", ADDR_CAPTURE, 32'h0);
        check("b1_rise_irq", {31'b0, irq}, 32'h0);
        in_port = 10'h005;
        tick(6);
        check("b1_fall_capture_pre", readdata, 32'h0);
        tick(1);
        check("b1_fall_capture", readdata, 32'h002);
        check("b1_fall_irq", {31'b0, irq}, 32'h1);
        av_write(ADDR_CAPTURE, 32'h002);
        tick(1);
        check("b1_clear_irq", {31'b0, irq}, 32'h0);
        check("b1_clear_capture", readdata, 32'h0);

        // Bit0 rise event on the same edge as a W1C of bit0: set wins.
        in_port = 10'h004;
        tick(8);
        av_read("coin_prep", ADDR_CAPTURE, 32'h0);
        in_port = 10'h005;
        tick(5);
        av_write(ADDR_CAPTURE, 32'h001);
        tick(1);
        check("coin_capture", readdata, 32'h001);
        check("coin_irq", {31'b0, irq}, 32'h1);
        av_write(ADDR_CAPTURE, 32'h001);

        // Reset while bit2 is mid-debounce.
        address = ADDR_DATA;
        in_port = 10'h001;
        tick(3);
        reset_n = 1'b0;
        tick(2);
        check("mid_rst_readdata", readdata, 32'h0);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(4);
        check("mid_rst_data", readdata, 32'h001);
        av_read("mid_rst_mask", ADDR_MASK, 32'h0);
        av_read("mid_rst_capture", ADDR_CAPTURE, 32'h0);
        av_read("mid_rst_edgesel", ADDR_EDGE_SEL, 32'h0);
        check("mid_rst_irq2", {31'b0, irq}, 32'h0);

        // Upper bits are not stored; DATA is read-only.
        av_write(ADDR_MASK, 32'hFFFF_FFFF);
        av_read("mask_width", ADDR_MASK, 32'h3FF);
        av_write(ADDR_DATA, 32'h3FF);
        av_read("data_ro", ADDR_DATA, 32'h001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
